// File: rtl/framebuf_uart_tx_if.sv
// framebuf_uart_tx_if: start/BRAM/UART signal bundle for the frame buffer dumper
interface framebuf_uart_tx_if #(
  parameter int ADDR_WIDTH = 4
);
  logic start;
  logic [7:0] mem_dout;
  logic mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic txd;
  logic busy;
  logic done;
  modport master (
    input start, mem_dout,
    output mem_en, mem_addr, txd, busy, done
  );
  modport slave (
    output start, mem_dout,
    input mem_en, mem_addr, txd, busy, done
  );
endinterface

// File: rtl/framebuf_uart_tx.sv
// framebuf_uart_tx: reads the frame buffer BRAM words 0..DEPTH-1 and sends each as an 8N1 UART frame
module framebuf_uart_tx #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int CLKS_PER_BIT = 208,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  framebuf_uart_tx_if.master bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [1:0] lat, lat_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic txd, txd_n;
  logic busy, busy_n;
  logic done, done_n;
  logic en, en_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic tick;
  logic last;
  assign tick = baud == BAUD_LAST;
  assign last = addr == ADDR_LAST;
  assign bus.txd = txd;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.mem_en = en;
  assign bus.mem_addr = addr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      lat <= '0;
      idx <= '0;
      sh <= '0;
      txd <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      en <= 1'b0;
      addr <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      lat <= lat_n;
      idx <= idx_n;
      sh <= sh_n;
      txd <= txd_n;
      busy <= busy_n;
      done <= done_n;
      en <= en_n;
      addr <= addr_n;
    end
  end
  always_comb begin
    state_n = state;
    baud_n = '0;
    lat_n = lat;
    idx_n = idx;
    sh_n = sh;
    txd_n = txd;
    busy_n = busy;
    done_n = 1'b0;
    en_n = en;
    addr_n = addr;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        addr_n = '0;
        if (bus.start) begin
          state_n = FETCH;
          busy_n = 1'b1;
          en_n = 1'b1;
          lat_n = '0;
        end
      end
      FETCH: begin
        lat_n = lat + 2'd1;
        if (lat == LAT_LAST) begin
          lat_n = '0;
          sh_n = bus.mem_dout;
          txd_n = 1'b0;
          en_n = 1'b0;
          state_n = START;
        end
      end
      START: begin
        baud_n = tick ? '0 : baud + 1'b1;
        if (tick) begin
          state_n = DATA;
          idx_n = '0;
          txd_n = sh[0];
        end
      end
      DATA: begin
        baud_n = tick ? '0 : baud + 1'b1;
        if (tick) begin
          sh_n = sh >> 1;
          idx_n = idx + 3'd1;
          txd_n = idx == 3'd7 ? 1'b1 : sh[1];
          state_n = idx == 3'd7 ? STOP : DATA;
        end
      end
      STOP: begin
        baud_n = tick ? '0 : baud + 1'b1;
        if (tick) begin
          state_n = last ? IDLE : FETCH;
          busy_n = !last;
          done_n = last;
          en_n = !last;
          lat_n = '0;
          addr_n = last ? '0 : addr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/framebuf_uart_tx.md
# framebuf_uart_tx

Reads the camera frame buffer back out and serialises it over a UART line. The buffer is the single-port block RAM that the camera capture path fills. On a `start` pulse the block fetches words 0 to DEPTH-1 in order and transmits each as an 8N1 frame on `txd`, then pulses `done`. It sits in the 24 MHz `clk_24M` domain beside the capture logic and drives the BRAM read port.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: width of `mem_addr`.
- `DEPTH`, 16: number of words sent per dump, addresses 0 to DEPTH-1. Legal range is 1 to 2^ADDR_WIDTH.
- `CLKS_PER_BIT`, 208: clock cycles per UART bit (24 MHz / 115200). Must be at least 2.
- `RD_LAT`, 1: BRAM read latency in cycles. Legal range is 1 to 3.

Ports:
- `clk`  in  1  system clock, wired to `clk_24M`.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a dump. Sampled only in IDLE.
- `mem_dout`  in  8  BRAM read data.
- `mem_en`  out  1  BRAM enable. High only in FETCH.
- `mem_addr`  out  ADDR_WIDTH  BRAM read address.
- `txd`  out  1  UART line. Idle level is 1.
- `busy`  out  1  high from the cycle after `start` is accepted until the dump ends.
- `done`  out  1  one-cycle pulse when the dump ends.

## Operation
- All outputs are registered.
- Reset values: `txd`=1, `busy`=0, `done`=0, `mem_en`=0, `mem_addr`=0, state IDLE, all counters 0.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - `txd`=1 and `mem_addr`=0.
  - If `start`=1: go to FETCH, set `busy`=1 and `mem_en`=1.
  - `start` is ignored in every other state; no queuing.
- FETCH:
  - `mem_en`=1 and `mem_addr` is held for RD_LAT cycles.
  - On the last FETCH cycle: capture `mem_dout` into the shift register, drive `txd`=0, go to START, drop `mem_en`.
- START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Eight bits, LSB first, each held for CLKS_PER_BIT cycles.
  - A 3-bit index counts the bits; the shift register shifts right once per bit.
- STOP: `txd`=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
  - If `mem_addr` = DEPTH-1: go to IDLE, set `busy`=0, pulse `done`, reset `mem_addr` to 0.
  - Otherwise: increment `mem_addr`, go to FETCH with `mem_en`=1.
- Address never wraps inside a dump. DEPTH=1 sends exactly word 0.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0 to CLKS_PER_BIT-1 and reloads to 0 on every bit boundary.
- `start` held high continuously:
  - A new dump begins in the IDLE cycle where `done`=1.
  - That `start` is accepted, so back-to-back dumps have exactly one idle cycle between them.
- Reset mid-frame: the next cycle shows reset values. `txd` returns high immediately, which may truncate a frame, and no `done` pulse is issued.
- BRAM contents are never written. Data changing during a dump is sent as read.

## Timing
- `start` sampled high at edge k gives:
  - `busy`=1, `mem_en`=1, `mem_addr`=0 after edge k+1.
  - First `txd` falling edge after edge k+1+RD_LAT.
- Byte period is 10*CLKS_PER_BIT + RD_LAT cycles. The extra RD_LAT cycles are idle-high gap time while the next word is fetched.
- Total dump, from the first `txd`=0 to the `done` pulse, is DEPTH*(10*CLKS_PER_BIT) + (DEPTH-1)*RD_LAT cycles.
- `done` is high for exactly one cycle, coincident with `busy` falling.
- `mem_dout` must be valid RD_LAT cycles after `mem_addr` and `mem_en` are presented. It is sampled on the last FETCH edge only.

## Test plan
Bench parameters: CLKS_PER_BIT=4, DEPTH=4, RD_LAT=1.
- Reset:
  - Stimulus: hold `reset` for 3 cycles with `start`=1.
  - Required: `txd`=1, `busy`=0, `done`=0, `mem_en`=0, `mem_addr`=0 throughout. No dump starts while `reset` is high.
- Single dump:
  - Stimulus: BRAM = {0x55, 0xA3, 0x00, 0xFF}, `start` pulsed at edge k.
  - Required: `txd` falls at edge k+2. Decoded bytes are 0x55, 0xA3, 0x00, 0xFF, LSB first. Each frame is 40 cycles with a 1-cycle high gap between frames. `done` pulses 163 cycles after the first falling edge.
- Start while busy:
  - Stimulus: pulse `start` again 50 cycles into a dump.
  - Required: the dump is unchanged, only 4 bytes are sent, and exactly one `done` pulse occurs.
- Continuous start:
  - Stimulus: hold `start`=1 for 2 dumps.
  - Required: the second dump's FETCH begins the cycle after the `done` pulse, and both dumps send identical byte sequences.
- Mid-frame reset:
  - Stimulus: assert `reset` during bit 3 of byte 1.
  - Required: `txd`=1 and `busy`=0 the next cycle, with no `done` pulse. A later `start` restarts from address 0.
- Latency sweep:
  - Stimulus: rerun the single dump with RD_LAT=3.
  - Required: first falling edge at k+4, byte period 43 cycles, same byte values.
